// File: rtl/cache_top_core.sv
// Set-associative trace-driven cache model with hit/miss/traffic counters.
// Optional CACHE_CHANGE_DETECT_EN: merge repeated identical requests.
module cache_top_core #(
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 4,
    parameter int ASSOC       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_policy,
    input  logic        replace_policy,
    input  logic [1:0]  inclusion_policy,
    input  logic [47:0] cache_addr,
    input  logic [7:0]  cache_op,
    output logic [11:0] num_reads,
    output logic [11:0] num_writes,
    output logic [11:0] num_misses,
    output logic [11:0] num_hits,
    output logic [31:0] curr_tag,
    output logic [11:0] curr_set
);

    localparam int SETS  = 1 << INDEX_BITS;
    localparam int TAG_W = 48 - OFFSET_BITS - INDEX_BITS;
    localparam int AGE_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam int WAY_W = AGE_W;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_W = 8'h57;

    logic             valid_q [SETS][ASSOC];
    logic             dirty_q [SETS][ASSOC];
    logic [TAG_W-1:0] tag_q   [SETS][ASSOC];
    logic [AGE_W-1:0] age_q   [SETS][ASSOC];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  is_read;
    logic                  is_write;
    logic                  accept;
    logic                  hit;
    logic                  fill;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim;
    logic [WAY_W-1:0]      way;
    logic [AGE_W-1:0]      max_age;
    logic [AGE_W-1:0]      old_age;
    logic                  unused_bits;

    assign idx         = cache_addr[OFFSET_BITS +: INDEX_BITS];
    assign tag         = cache_addr[47 -: TAG_W];
    assign is_read     = (cache_op == OP_R);
    assign is_write    = (cache_op == OP_W);
    assign unused_bits = ^{inclusion_policy, cache_addr[OFFSET_BITS-1:0]};

`ifdef CACHE_CHANGE_DETECT_EN
    logic        last_valid;
    logic [55:0] last_req;

    assign accept = (is_read || is_write) &&
                    (!last_valid || ({cache_addr, cache_op} != last_req));
`else
    assign accept = is_read || is_write;
`endif

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Oldest way first, then override with the lowest invalid way.
        victim  = '0;
        max_age = age_q[idx][0];
        for (int w = 1; w < ASSOC; w++) begin
            if (age_q[idx][w] > max_age) begin
                max_age = age_q[idx][w];
                victim  = WAY_W'(w);
            end
        end
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) victim = WAY_W'(w);
        end
        way     = hit ? hit_way : victim;
        old_age = age_q[idx][way];
        fill    = !hit && !(is_write && write_policy);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= '0;
                end
            end
            num_reads  <= '0;
            num_writes <= '0;
            num_misses <= '0;
            num_hits   <= '0;
            curr_tag   <= '0;
            curr_set   <= '0;
`ifdef CACHE_CHANGE_DETECT_EN
            last_valid <= 1'b0;
            last_req   <= '0;
`endif
        end else if (accept) begin
            curr_tag <= 32'(tag);
            curr_set <= 12'(idx);
`ifdef CACHE_CHANGE_DETECT_EN
            last_valid <= 1'b1;
            last_req   <= {cache_addr, cache_op};
`endif
            if (hit) begin
                num_hits <= sat_inc(num_hits);
                if (is_write) begin
                    if (write_policy) num_writes <= sat_inc(num_writes);
                    else dirty_q[idx][way] <= 1'b1;
                end
            end else begin
                num_misses <= sat_inc(num_misses);
                if (!fill) begin
                    num_writes <= sat_inc(num_writes);
                end else begin
                    num_reads <= sat_inc(num_reads);
                    if (valid_q[idx][way] && dirty_q[idx][way])
                        num_writes <= sat_inc(num_writes);
                    valid_q[idx][way] <= 1'b1;
                    tag_q[idx][way]   <= tag;
                    dirty_q[idx][way] <= is_write;
                end
            end
            // A fill ages every other valid way; an LRU hit ages younger ones.
            if (fill || (hit && !replace_policy)) begin
                for (int w = 0; w < ASSOC; w++) begin
                    if (WAY_W'(w) == way)
                        age_q[idx][w] <= '0;
                    else if (valid_q[idx][w] &&
                             (fill || age_q[idx][w] < old_age))
                        age_q[idx][w] <= age_q[idx][w] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_top_core.sv
// Scoreboard bench for cache_top_core: queue-based reference model,
// directed scenarios plus randomized traces.
module tb_cache_top_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_policy = 1'b0;
    logic        replace_policy = 1'b0;
    logic [1:0]  inclusion_policy = 2'd0;
    logic [47:0] cache_addr = '0;
    logic [7:0]  cache_op = 8'h00;
    logic [11:0] num_reads;
    logic [11:0] num_writes;
    logic [11:0] num_misses;
    logic [11:0] num_hits;
    logic [31:0] curr_tag;
    logic [11:0] curr_set;

    cache_top_core dut (
        .clk(clk),
        .reset(reset),
        .write_policy(write_policy),
        .replace_policy(replace_policy),
        .inclusion_policy(inclusion_policy),
        .cache_addr(cache_addr),
        .cache_op(cache_op),
        .num_reads(num_reads),
        .num_writes(num_writes),
        .num_misses(num_misses),
        .num_hits(num_hits),
        .curr_tag(curr_tag),
        .curr_set(curr_set)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] R = 8'h52;
    localparam logic [7:0] W = 8'h57;

    typedef struct {
        logic [37:0] tag;
        bit          dirty;
    } line_t;

    typedef struct {
        int          r;
        int          w;
        int          m;
        int          h;
        logic [31:0] tag;
        logic [11:0] set;
    } snap_t;

    // Each set is a recency/arrival list, most recent at the front.
    line_t sets_q [16][$];
    snap_t exp_q[$];
    int mr, mw, mm, mh;
    logic [31:0] mtag;
    logic [11:0] mset;
    bit          last_v;
    logic [55:0] last_req;
    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] sat(int v);
        return (v > 4095) ? 32'd4095 : 32'(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 16; s++) sets_q[s].delete();
        mr = 0; mw = 0; mm = 0; mh = 0;
        mtag = '0; mset = '0;
        last_v = 1'b0;
        last_req = '0;
    endtask

    task automatic model_access(logic [7:0] op, logic [47:0] a);
        bit rd, wr;
        int s;
        int found;
        logic [37:0] t;
        line_t e;
        rd = (op == R);
        wr = (op == W);
        if (!(rd || wr)) return;
`ifdef CACHE_CHANGE_DETECT_EN
        if (last_v && last_req == {a, op}) return;
        last_v = 1'b1;
        last_req = {a, op};
`endif
        s = int'(a[9:6]);
        t = a[47:10];
        found = -1;
        foreach (sets_q[s][i]) if (sets_q[s][i].tag == t) found = i;
        if (found >= 0) begin
            mh++;
            if (wr) begin
                if (write_policy) mw++;
                else sets_q[s][found].dirty = 1'b1;
            end
            if (!replace_policy) begin
                e = sets_q[s][found];
                sets_q[s].delete(found);
                sets_q[s].push_front(e);
            end
        end else begin
            mm++;
            if (wr && write_policy) begin
                mw++;
            end else begin
                mr++;
                if (sets_q[s].size() == 2) begin
                    e = sets_q[s].pop_back();
                    if (e.dirty) mw++;
                end
                e.tag = t;
                e.dirty = wr;
                sets_q[s].push_front(e);
            end
        end
        mtag = t[31:0];
        mset = 12'(s);
    endtask

    task automatic step(logic [7:0] op, logic [47:0] a);
        snap_t sn;
        cache_op = op;
        cache_addr = a;
        @(posedge clk);
        #1;
        model_access(op, a);
        sn.r = mr; sn.w = mw; sn.m = mm; sn.h = mh;
        sn.tag = mtag; sn.set = mset;
        exp_q.push_back(sn);
    endtask

    task automatic do_reset();
        cache_op = 8'h00;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_reads", 32'(num_reads), 0);
        chk("rst_writes", 32'(num_writes), 0);
        chk("rst_misses", 32'(num_misses), 0);
        chk("rst_hits", 32'(num_hits), 0);
        chk("rst_tag", curr_tag, 0);
        chk("rst_set", 32'(curr_set), 0);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic expect_cnt(string name, int r, int w, int m, int h);
        cache_op = 8'h00;
        @(negedge clk);
        #1;
        chk({name, "_reads"}, 32'(num_reads), 32'(r));
        chk({name, "_writes"}, 32'(num_writes), 32'(w));
        chk({name, "_misses"}, 32'(num_misses), 32'(m));
        chk({name, "_hits"}, 32'(num_hits), 32'(h));
    endtask

    // Monitor: results become visible after the accepting edge.
    always @(negedge clk) begin
        snap_t s;
        if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            chk("sb_reads", 32'(num_reads), sat(s.r));
            chk("sb_writes", 32'(num_writes), sat(s.w));
            chk("sb_misses", 32'(num_misses), sat(s.m));
            chk("sb_hits", 32'(num_hits), sat(s.h));
            chk("sb_tag", curr_tag, s.tag);
            chk("sb_set", 32'(curr_set), 32'(s.set));
        end
    end

    initial begin
        logic [47:0] a;
        logic [47:0] prev_a;
        logic [7:0]  op;
        logic [7:0]  prev_op;
        logic [37:0] t;
        int k;

        model_reset();
        do_reset();

        write_policy = 1'b0;
        replace_policy = 1'b0;
        do_reset();
        step(W, 48'h7fff493822b8);
        expect_cnt("wb_first", 1, 0, 1, 0);
        chk("wb_first_set", 32'(curr_set), 32'd10);
        chk("wb_first_tag", curr_tag, 32'hFFD24E08);
        step(W, 48'h7fff493822b0);
        expect_cnt("wb_same_blk", 1, 0, 1, 1);

        do_reset();
        step(W, 48'h000); step(W, 48'h400);
        step(W, 48'h800); step(R, 48'h000);
        expect_cnt("dirty_evict", 4, 2, 4, 0);

        do_reset();
        step(W, 48'h000); step(W, 48'h400); step(R, 48'h000);
        step(W, 48'h800); step(R, 48'h000);
        expect_cnt("lru", 3, 1, 3, 2);

        replace_policy = 1'b1;
        do_reset();
        step(W, 48'h000); step(W, 48'h400); step(R, 48'h000);
        step(W, 48'h800); step(R, 48'h000);
        expect_cnt("fifo", 4, 2, 4, 1);

        write_policy = 1'b1;
        replace_policy = 1'b0;
        do_reset();
        step(W, 48'h1000); step(R, 48'h1000); step(W, 48'h1000);
        expect_cnt("wthru", 1, 2, 2, 1);

        write_policy = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step(R, 48'h2000);
`ifdef CACHE_CHANGE_DETECT_EN
        expect_cnt("hold", 1, 0, 1, 0);
`else
        expect_cnt("hold", 1, 0, 1, 4);
`endif
        step(8'h00, 48'h2000);
        step(8'h41, 48'h4000);
`ifdef CACHE_CHANGE_DETECT_EN
        expect_cnt("illegal_op", 1, 0, 1, 0);
`else
        expect_cnt("illegal_op", 1, 0, 1, 4);
`endif
        do_reset();
        step(R, 48'h2000);
        expect_cnt("post_reset", 1, 0, 1, 0);

        for (int p = 0; p < 4; p++) begin
            write_policy = p[0];
            replace_policy = p[1];
            do_reset();
            prev_a = '0;
            prev_op = 8'h00;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(9) == 0) replace_policy = ~replace_policy;
                if ($urandom_range(4) == 0) begin
                    a = prev_a;
                    op = prev_op;
                end else begin
                    k = int'($urandom_range(3));
                    t = 38'h2A12345678 + 38'(k) * 38'h1000000001;
                    a = {t, 4'($urandom_range(3)), 6'($urandom_range(63))};
                    case ($urandom_range(9))
                        0: op = 8'h00;
                        1: op = 8'h72;
                        2, 3, 4, 5: op = R;
                        default: op = W;
                    endcase
                end
                step(op, a);
                prev_a = a;
                prev_op = op;
            end
            cache_op = 8'h00;
            @(negedge clk);
            #1;
        end

        write_policy = 1'b0;
        replace_policy = 1'b0;
        do_reset();
        for (int i = 0; i < 4200; i++) step(R, 48'h3000 + 48'(i & 1));
`ifdef CACHE_CHANGE_DETECT_EN
        expect_cnt("saturate", 1, 0, 1, 4095);
`else
        expect_cnt("saturate", 1, 0, 1, 4095);
`endif

        @(negedge clk);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
